// File: rtl/seg7_pkg.sv
// seg7_pkg: digit type, active-low seven-segment table and lookup helper.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 first: F, E, d, C, b, A, 9 .. 0 ({g,f,e,d,c,b,a}, active-low).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input digit_t d);
        return SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and single-cycle rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic          hit;

    // Counter only runs while the synchronized sample disagrees with the accepted level.
    assign hit = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= (sync_q[1] == level_q || hit) ? '0 : cnt_q + CW'(1);
            level_q <= hit ? sync_q[1] : level_q;
            pulse_q <= hit && sync_q[1];
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/seg7_multi_counter.sv
// seg7_multi_counter: debounced up/down hex/BCD counter shown on a multiplexed
// active-low seven-segment display with optional leading-zero blanking.
module seg7_multi_counter
    import seg7_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DOT_POS         = 2
) (
    input  logic                FPGA_clk,
    input  logic                rst,
    input  logic                incr_btn,
    input  logic                decr_btn,
    input  logic                mode_dec,
    input  logic                blank_lz,
    output logic [6:0]          LED_segments,
    output logic                LED_dot,
    output logic [N_DIGITS-1:0] LED_en
);

    localparam int CW = 4 * N_DIGITS;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);

    logic                inc_p, dec_p;
    logic [2:0]          mode_q;
    logic                mode_chg;
    digit_t              dmax, d;
    logic                cy, bw;
    logic [CW-1:0]       cnt_q, cnt_d, inc_v, dec_v, snap_q, upper;
    logic [RW-1:0]       ref_q;
    logic [IW-1:0]       idx_q;
    logic                tick, blank;
    logic [6:0]          seg_q;
    logic                dot_q;
    logic [N_DIGITS-1:0] en_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_incr (
        .clk_i(FPGA_clk), .rst_ni(rst), .btn_i(incr_btn), .pulse_o(inc_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_decr (
        .clk_i(FPGA_clk), .rst_ni(rst), .btn_i(decr_btn), .pulse_o(dec_p)
    );

    assign mode_chg = mode_q[2] ^ mode_q[1];
    assign dmax     = mode_q[1] ? 4'd9 : 4'd15;

    // Per-digit ripple: a digit rolls over only while every lower digit does.
    always_comb begin
        inc_v = cnt_q;
        dec_v = cnt_q;
        cy    = 1'b1;
        bw    = 1'b1;
        d     = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = cnt_q[4*i +: 4];
            inc_v[4*i +: 4] = !cy ? d : (d == dmax) ? 4'd0 : d + 4'd1;
            dec_v[4*i +: 4] = !bw ? d : (d == 4'd0) ? dmax : d - 4'd1;
            cy = cy && (d == dmax);
            bw = bw && (d == 4'd0);
        end
    end

    assign cnt_d = mode_chg ? '0 :
                   (inc_p && !dec_p) ? inc_v :
                   (dec_p && !inc_p) ? dec_v : cnt_q;

    assign tick  = (ref_q == RW'(REFRESH_DIV - 1));
    assign upper = snap_q >> (4 * idx_q);
    assign blank = blank_lz && (idx_q != '0) && (upper == '0);

    // The display reads a snapshot taken at slot boundaries so a slot never tears.
    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            mode_q <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
            ref_q  <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            dot_q  <= 1'b1;
            en_q   <= '1;
        end else begin
            mode_q <= {mode_q[1:0], mode_dec};
            cnt_q  <= cnt_d;
            snap_q <= tick ? cnt_q : snap_q;
            ref_q  <= tick ? '0 : ref_q + RW'(1);
            idx_q  <= !tick ? idx_q : (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            seg_q  <= blank ? SEG_BLANK : hex2seg(upper[3:0]);
            dot_q  <= int'(idx_q) != DOT_POS;
            en_q   <= ~(N_DIGITS'(1) << idx_q);
        end
    end

    assign LED_segments = seg_q;
    assign LED_dot      = dot_q;
    assign LED_en       = en_q;

endmodule

// File: tb/tb_seg7_multi_counter.sv
// tb_seg7_multi_counter: randomized button/mode stimulus checked against an integer count model.
module tb_seg7_multi_counter;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DB = 8;

    logic FPGA_clk = 0, rst = 0, incr_btn = 0, decr_btn = 0, mode_dec = 0, blank_lz = 0;
    logic [6:0]   LED_segments;
    logic         LED_dot;
    logic [N-1:0] LED_en;

    int n_checks = 0, n_pass = 0;
    int model_cnt = 0;
    bit model_dec = 0;
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] disp_seg [N];
    logic       disp_dot [N];

    seg7_multi_counter #(.N_DIGITS(N), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DB), .DOT_POS(2)) dut (
        .FPGA_clk(FPGA_clk), .rst(rst), .incr_btn(incr_btn), .decr_btn(decr_btn),
        .mode_dec(mode_dec), .blank_lz(blank_lz), .LED_segments(LED_segments),
        .LED_dot(LED_dot), .LED_en(LED_en)
    );

    always #5 FPGA_clk = ~FPGA_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int modulus();
        int m = 1;
        for (int j = 0; j < N; j++) m *= model_dec ? 10 : 16;
        return m;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        int base = model_dec ? 10 : 16;
        int q = model_cnt;
        for (int j = 0; j < i; j++) q /= base;
        if (blank_lz && i > 0 && q == 0) return 7'h7F;
        return seg_ref[q % base];
    endfunction

    task automatic press(input bit inc, input bit dec, input int hold);
        int m = modulus();
        @(negedge FPGA_clk);
        incr_btn = inc;
        decr_btn = dec;
        repeat (hold) @(negedge FPGA_clk);
        incr_btn = 0;
        decr_btn = 0;
        repeat (14) @(negedge FPGA_clk);
        if (hold >= DB && inc && !dec) model_cnt = (model_cnt + 1) % m;
        if (hold >= DB && dec && !inc) model_cnt = (model_cnt + m - 1) % m;
    endtask

    task automatic set_mode(input bit m);
        mode_dec = m;
        if (m != model_dec) begin
            model_dec = m;
            model_cnt = 0;
        end
        repeat (8) @(negedge FPGA_clk);
    endtask

    task automatic check_disp(input string tag);
        logic [N-1:0] seen = '0;
        repeat (N*RD + 2) @(negedge FPGA_clk);
        for (int k = 0; k < 8*N*RD && seen != {N{1'b1}}; k++) begin
            @(negedge FPGA_clk);
            for (int i = 0; i < N; i++)
                if (LED_en == ~(N'(1) << i)) begin
                    disp_seg[i] = LED_segments;
                    disp_dot[i] = LED_dot;
                    seen[i] = 1'b1;
                end
        end
        check({tag, " scan"}, 32'(seen), (1 << N) - 1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s seg%0d", tag, i), 32'(disp_seg[i]), 32'(exp_seg(i)));
            check($sformatf("%s dot%0d", tag, i), 32'(disp_dot[i]), (i == 2) ? 0 : 1);
        end
    endtask

    initial begin
        bit found = 0;
        repeat (5) @(negedge FPGA_clk);
        check("rst seg", 32'(LED_segments), 32'h7F);
        check("rst en", 32'(LED_en), 32'hF);
        check("rst dot", 32'(LED_dot), 1);
        rst = 1;
        for (int k = 0; k < RD + 1 && !found; k++) begin
            @(negedge FPGA_clk);
            found = (LED_segments == 7'h40) && (LED_en == 4'hE);
        end
        check("first slot", 32'(found), 1);

        press(1, 0, 3);   check_disp("short");
        press(1, 0, 20);  check_disp("one");
        press(1, 0, 20);  check_disp("two");

        set_mode(1);      check_disp("bcd clr");
        press(0, 1, 20);  check_disp("bcd 9999");
        press(1, 0, 20);  check_disp("bcd 0000");

        set_mode(0);      check_disp("hex clr");
        press(0, 1, 20);  check_disp("hex ffff");
        press(1, 0, 20);  check_disp("hex 0000");

        repeat (5) press(1, 0, 15);
        press(1, 1, 15);  check_disp("both");
        set_mode(1);      check_disp("mode clr");
        set_mode(0);

        repeat (18) press(1, 0, 12);
        blank_lz = 1;     check_disp("blank");

        for (int n = 0; n < 40; n++) begin
            int op   = $urandom_range(0, 9);
            int hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(12, 25);
            if (op == 0) set_mode(!model_dec);
            else if (op == 1) blank_lz = 1'($urandom_range(0, 1));
            else if (op <= 5) press(1, 0, hold);
            else if (op <= 8) press(0, 1, hold);
            else press(1, 1, hold);
            check_disp($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
